// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wr_arbiter_pkg;

   localparam logic [3:0] REG_PC = 4'hF;

   // Address-match query slots presented to each writeback queue.
   localparam int NQ     = 3;
   localparam int Q_RA1  = 0;
   localparam int Q_RA2  = 1;
   localparam int Q_XREQ = 2;

   typedef struct packed {
      logic [3:0]  addr;
      logic [31:0] data;
   } wb_req_t;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_e;

endpackage

// File: rtl/regfile_wr_arbiter_wb_fifo.sv
// Per-requester writeback FIFO with occupancy flags and an address-match
// vector over its live entries.
module wb_fifo
   import regfile_wr_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  wb_req_t                i_din,
   input  logic                   i_pop,
   output wb_req_t                o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count,
   input  logic [NQ-1:0][3:0]     i_q_addr,
   output logic [NQ-1:0]          o_match
);

   localparam int PW = $clog2(DEPTH);

   wb_req_t         r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW:0]     r_count;

   // NOTE: storage is not reset; pointers and occupancy alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_din;
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == (PW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   // NOTE: default first so no path through the loop leaves o_match unassigned (no latch).
   always_comb begin
      o_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < int'(r_count)) begin
            for (int q = 0; q < NQ; q++) begin
               if (r_mem[r_rd_ptr + PW'(i)].addr == i_q_addr[q]) o_match[q] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write
// port, with WAW ordering stalls, R15 drop and read-hazard flags.
module regfile_wr_arbiter
   import regfile_wr_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [3:0]  alu_addr,
   input  logic [31:0] alu_data,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [3:0]  mem_addr,
   input  logic [31:0] mem_data,
   output logic        we3,
   output logic [3:0]  wa3,
   output logic [31:0] wd3,
   input  logic [3:0]  ra1,
   input  logic [3:0]  ra2,
   output logic        hazard1,
   output logic        hazard2,
   output logic        err_r15
);

   localparam int CW = $clog2(DEPTH) + 1;

   wb_req_t         w_alu_din, w_mem_din, w_alu_head, w_mem_head, w_gnt_entry;
   logic            w_alu_full, w_alu_empty, w_mem_full, w_mem_empty;
   logic [CW-1:0]   w_alu_count, w_mem_count;
   logic [NQ-1:0]   w_alu_match, w_mem_match;
   logic            w_alu_ready, w_mem_ready;
   logic            w_alu_hs, w_mem_hs, w_alu_push, w_mem_push;
   logic            w_alu_pop, w_mem_pop, w_gnt_valid;
   req_e            w_gnt;

   req_e            r_prio;
   logic            r_we3;
   logic [3:0]      r_wa3;
   logic [31:0]     r_wd3;
   logic            r_err;

   assign w_alu_din = '{addr: alu_addr, data: alu_data};
   assign w_mem_din = '{addr: mem_addr, data: mem_data};

   // A same-address tie goes to mem, so alu also yields to an accepted mem request.
   assign w_mem_ready = rst_n & ~w_mem_full & ~w_alu_match[Q_XREQ];
   assign w_alu_ready = rst_n & ~w_alu_full & ~w_mem_match[Q_XREQ]
                      & ~(mem_valid & w_mem_ready & (mem_addr == alu_addr));

   assign w_alu_hs   = alu_valid & w_alu_ready;
   assign w_mem_hs   = mem_valid & w_mem_ready;
   assign w_alu_push = w_alu_hs & (alu_addr != REG_PC);
   assign w_mem_push = w_mem_hs & (mem_addr != REG_PC);

   wb_fifo #(.DEPTH(DEPTH)) u_alu_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_push   (w_alu_push),
      .i_din    (w_alu_din),
      .i_pop    (w_alu_pop),
      .o_head   (w_alu_head),
      .o_full   (w_alu_full),
      .o_empty  (w_alu_empty),
      .o_count  (w_alu_count),
      .i_q_addr ({mem_addr, ra2, ra1}),
      .o_match  (w_alu_match)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_mem_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_push   (w_mem_push),
      .i_din    (w_mem_din),
      .i_pop    (w_mem_pop),
      .o_head   (w_mem_head),
      .o_full   (w_mem_full),
      .o_empty  (w_mem_empty),
      .o_count  (w_mem_count),
      .i_q_addr ({alu_addr, ra2, ra1}),
      .o_match  (w_mem_match)
   );

   always_comb begin
      w_gnt = r_prio;
      if (w_alu_empty)      w_gnt = REQ_MEM;
      else if (w_mem_empty) w_gnt = REQ_ALU;
   end

   assign w_gnt_valid = ~(w_alu_empty & w_mem_empty);
   assign w_alu_pop   = w_gnt_valid & (w_gnt == REQ_ALU);
   assign w_mem_pop   = w_gnt_valid & (w_gnt == REQ_MEM);
   assign w_gnt_entry = (w_gnt == REQ_MEM) ? w_mem_head : w_alu_head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= REQ_MEM;
         r_we3  <= 1'b0;
         r_wa3  <= '0;
         r_wd3  <= '0;
         r_err  <= 1'b0;
      end else begin
         r_we3 <= w_gnt_valid;
         r_err <= (w_alu_hs & (alu_addr == REG_PC)) | (w_mem_hs & (mem_addr == REG_PC));
         if (w_gnt_valid) begin
            r_wa3  <= w_gnt_entry.addr;
            r_wd3  <= w_gnt_entry.data;
            r_prio <= (w_gnt == REQ_MEM) ? REQ_ALU : REQ_MEM;
         end
      end
   end

   // The regfile captures on the following negedge, so the in-flight write still counts.
   assign hazard1 = (ra1 != REG_PC)
                  & (w_alu_match[Q_RA1] | w_mem_match[Q_RA1] | (r_we3 & (r_wa3 == ra1)));
   assign hazard2 = (ra2 != REG_PC)
                  & (w_alu_match[Q_RA2] | w_mem_match[Q_RA2] | (r_we3 & (r_wa3 == ra2)));

   assign alu_ready = w_alu_ready;
   assign mem_ready = w_mem_ready;
   assign we3       = r_we3;
   assign wa3       = r_wa3;
   assign wd3       = r_wd3;
   assign err_r15   = r_err;

   a_occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
      (w_alu_count <= CW'(DEPTH)) && (w_mem_count <= CW'(DEPTH)));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: per-cycle vector table for ready/hazard plus a
// write-order scoreboard and hand sequences for multi-cycle corners.
module tb_regfile_wr_arbiter;
   import regfile_wr_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_valid, alu_ready, mem_valid, mem_ready;
   logic [3:0]  alu_addr, mem_addr, wa3, ra1, ra2;
   logic [31:0] alu_data, mem_data, wd3;
   logic        we3, hazard1, hazard2, err_r15;

   int n_checks = 0;
   int n_fail   = 0;
   wb_req_t exp_q[$];

   typedef struct {
      int av, aa, mv, ma, r1, r2;
      int ear, emr, eh1, eh2;
   } vec_t;
   vec_t tbl[12];

   regfile_wr_arbiter #(.DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_addr  (alu_addr),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .ra1       (ra1),
      .ra2       (ra2),
      .hazard1   (hazard1),
      .hazard2   (hazard2),
      .err_r15   (err_r15)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dat(input int is_mem, input int tag, input int addr);
      return {(is_mem != 0) ? 8'hBB : 8'hAA, 8'(tag), 12'h000, 4'(addr)};
   endfunction

   task automatic push_exp(input int addr, input logic [31:0] data);
      exp_q.push_back('{addr: 4'(addr), data: data});
   endtask

   task automatic drive(input int av, input int aa, input logic [31:0] ad,
                        input int mv, input int ma, input logic [31:0] md);
      alu_valid = 1'(av);
      alu_addr  = 4'(aa);
      alu_data  = ad;
      mem_valid = 1'(mv);
      mem_addr  = 4'(ma);
      mem_data  = md;
   endtask

   task automatic idle();
      drive(0, 0, 32'h0, 0, 0, 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Write-port scoreboard: every we3 pulse must match the next expected write.
   always @(negedge clk) begin
      if (rst_n && we3) begin
         if (exp_q.size() == 0) begin
            check("unexpected_we3", 32'(we3), 32'd0);
         end else begin
            wb_req_t e;
            e = exp_q.pop_front();
            check("wr_wa3", 32'(wa3), 32'(e.addr));
            check("wr_wd3", wd3, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // av aa mv ma r1 r2 | alu_rdy mem_rdy haz1 haz2
      tbl[0]  = '{1, 1, 1, 1, 1, 0,  0, 1, 0, 0};
      tbl[1]  = '{1, 1, 0, 0, 1, 2,  0, 1, 1, 0};
      tbl[2]  = '{1, 1, 1, 2, 1, 2,  1, 1, 1, 0};
      tbl[3]  = '{1, 2, 1, 1, 2, 15, 0, 0, 1, 0};
      tbl[4]  = '{1, 3, 1, 4, 1, 2,  1, 1, 1, 1};
      tbl[5]  = '{1, 5, 1, 6, 3, 4,  1, 1, 1, 1};
      tbl[6]  = '{1, 7, 1, 8, 2, 6,  1, 0, 0, 1};
      tbl[7]  = '{1, 9, 0, 0, 7, 4,  0, 1, 1, 1};
      tbl[8]  = '{0, 0, 0, 0, 0, 15, 1, 1, 0, 0};
      tbl[9]  = '{0, 0, 0, 0, 7, 6,  1, 1, 1, 1};
      tbl[10] = '{0, 0, 0, 0, 7, 6,  1, 1, 1, 0};
      tbl[11] = '{0, 0, 0, 0, 7, 6,  1, 1, 0, 0};

      ra1 = 4'd0;
      ra2 = 4'd0;
      drive(1, 2, 32'h1, 1, 3, 32'h2);
      #2;
      check("rst_alu_ready", 32'(alu_ready), 32'd0);
      check("rst_mem_ready", 32'(mem_ready), 32'd0);
      check("rst_we3", 32'(we3), 32'd0);
      check("rst_wa3", 32'(wa3), 32'd0);
      check("rst_wd3", wd3, 32'd0);
      check("rst_err_r15", 32'(err_r15), 32'd0);
      do_reset();

      // Vector table: one row per cycle, queue state carried from row to row.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(tbl[i].av, tbl[i].aa, dat(0, i, tbl[i].aa),
               tbl[i].mv, tbl[i].ma, dat(1, i, tbl[i].ma));
         ra1 = 4'(tbl[i].r1);
         ra2 = 4'(tbl[i].r2);
         #1;
         check($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].ear));
         check($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].emr));
         check($sformatf("v%0d_hazard1", i), 32'(hazard1), 32'(tbl[i].eh1));
         check($sformatf("v%0d_hazard2", i), 32'(hazard2), 32'(tbl[i].eh2));
         if (tbl[i].av != 0 && tbl[i].ear != 0 && tbl[i].aa != 15) push_exp(tbl[i].aa, dat(0, i, tbl[i].aa));
         if (tbl[i].mv != 0 && tbl[i].emr != 0 && tbl[i].ma != 15) push_exp(tbl[i].ma, dat(1, i, tbl[i].ma));
      end
      @(negedge clk);
      idle();
      drain("tbl_drain");

      // Single write latency and read hazard tracking.
      do_reset();
      @(negedge clk);
      drive(1, 3, 32'hDEADBEEF, 0, 0, 32'h0);
      ra1 = 4'd3;
      #1;
      check("sw_alu_ready", 32'(alu_ready), 32'd1);
      check("sw_haz_empty", 32'(hazard1), 32'd0);
      push_exp(3, 32'hDEADBEEF);
      @(negedge clk);
      idle();
      check("sw_we3_c1", 32'(we3), 32'd0);
      #1;
      check("sw_haz_queued", 32'(hazard1), 32'd1);
      @(negedge clk);
      check("sw_we3_c2", 32'(we3), 32'd1);
      check("sw_wa3", 32'(wa3), 32'd3);
      check("sw_wd3", wd3, 32'hDEADBEEF);
      #1;
      check("sw_haz_inflight", 32'(hazard1), 32'd1);
      @(negedge clk);
      #1;
      check("sw_we3_c3", 32'(we3), 32'd0);
      check("sw_haz_clear", 32'(hazard1), 32'd0);
      drain("sw_drain");

      // Round-robin from reset: mem favoured first, then alternate.
      do_reset();
      @(negedge clk);
      drive(1, 1, dat(0, 20, 1), 1, 5, dat(1, 20, 5));
      #1;
      check("rr_c1_alu_ready", 32'(alu_ready), 32'd1);
      check("rr_c1_mem_ready", 32'(mem_ready), 32'd1);
      push_exp(5, dat(1, 20, 5));
      push_exp(1, dat(0, 20, 1));
      @(negedge clk);
      drive(1, 2, dat(0, 21, 2), 1, 6, dat(1, 21, 6));
      #1;
      check("rr_c2_alu_ready", 32'(alu_ready), 32'd1);
      check("rr_c2_mem_ready", 32'(mem_ready), 32'd1);
      push_exp(6, dat(1, 21, 6));
      push_exp(2, dat(0, 21, 2));
      @(negedge clk);
      idle();
      drain("rr_drain");

      // Full alu queue holds off ready until a pop.
      do_reset();
      @(negedge clk);
      drive(1, 1, dat(0, 30, 1), 1, 9, dat(1, 30, 9));
      #1;
      check("full_c1_ready", 32'(alu_ready & mem_ready), 32'd1);
      push_exp(9, dat(1, 30, 9));
      push_exp(1, dat(0, 30, 1));
      @(negedge clk);
      drive(1, 2, dat(0, 31, 2), 1, 10, dat(1, 31, 10));
      #1;
      check("full_c2_ready", 32'(alu_ready & mem_ready), 32'd1);
      push_exp(10, dat(1, 31, 10));
      push_exp(2, dat(0, 31, 2));
      @(negedge clk);
      drive(1, 3, dat(0, 32, 3), 0, 0, 32'h0);
      #1;
      check("full_alu_ready_low", 32'(alu_ready), 32'd0);
      @(negedge clk);
      #1;
      check("full_alu_ready_back", 32'(alu_ready), 32'd1);
      push_exp(3, dat(0, 32, 3));
      @(negedge clk);
      idle();
      drain("full_drain");

      // WAW stall: alu to addr 7 waits for the queued mem write to 7.
      do_reset();
      @(negedge clk);
      drive(0, 0, 32'h0, 1, 3, dat(1, 40, 3));
      #1;
      check("waw_c1_mem_ready", 32'(mem_ready), 32'd1);
      push_exp(3, dat(1, 40, 3));
      @(negedge clk);
      drive(1, 1, dat(0, 41, 1), 1, 7, dat(1, 41, 7));
      #1;
      check("waw_c2_ready", 32'(alu_ready & mem_ready), 32'd1);
      push_exp(1, dat(0, 41, 1));
      push_exp(7, dat(1, 41, 7));
      @(negedge clk);
      drive(1, 7, dat(0, 42, 7), 0, 0, 32'h0);
      #1;
      check("waw_stall_c3", 32'(alu_ready), 32'd0);
      @(negedge clk);
      #1;
      check("waw_stall_c4", 32'(alu_ready), 32'd0);
      @(negedge clk);
      #1;
      check("waw_release", 32'(alu_ready), 32'd1);
      push_exp(7, dat(0, 42, 7));
      @(negedge clk);
      idle();
      drain("waw_drain");

      // R15 drop: one-cycle error pulse, nothing written.
      do_reset();
      @(negedge clk);
      drive(0, 0, 32'h0, 1, 15, 32'h12345678);
      #1;
      check("r15_mem_ready", 32'(mem_ready), 32'd1);
      check("r15_err_before", 32'(err_r15), 32'd0);
      @(negedge clk);
      idle();
      check("r15_err_pulse", 32'(err_r15), 32'd1);
      check("r15_we3_c1", 32'(we3), 32'd0);
      @(negedge clk);
      check("r15_err_gone", 32'(err_r15), 32'd0);
      check("r15_we3_c2", 32'(we3), 32'd0);
      @(negedge clk);
      check("r15_we3_c3", 32'(we3), 32'd0);

      // Reset with three entries queued and a write in flight.
      do_reset();
      @(negedge clk);
      drive(1, 1, dat(0, 50, 1), 1, 5, dat(1, 50, 5));
      push_exp(5, dat(1, 50, 5));
      @(negedge clk);
      drive(1, 2, dat(0, 51, 2), 1, 6, dat(1, 51, 6));
      @(negedge clk);
      idle();
      check("mid_we3_before", 32'(we3), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_we3_async", 32'(we3), 32'd0);
      check("mid_wa3_async", 32'(wa3), 32'd0);
      check("mid_wd3_async", wd3, 32'd0);
      check("mid_ready_in_rst", 32'({alu_ready, mem_ready}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("mid_ready_after", 32'({alu_ready, mem_ready}), 32'd3);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("mid_no_write_%0d", k), 32'(we3), 32'd0);
      end
      drain("mid_drain");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
